// File: rtl/l1_biu_line_fetch_if.sv
// Interface between the L1-I controller, the line-fetch BIU and the 8-bit SoC req/ack bus.
// The slave modport is the BIU; the master modport is its environment (controller and memory).
interface l1_biu_line_fetch_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int LINE_WID   = 8
);
    logic                  read_line_req;
    logic                  read_req;
    logic                  write_through_req;
    logic [ADDR_WIDTH-1:0] pa;
    logic [7:0]            wt_data;
    logic [7:0]            line_data;
    logic [LINE_WID-1:0]   addr_count;
    logic                  line_write;
    logic                  cache_entry_refill;
    logic                  trans_rdy;
    logic                  bus_error;
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [7:0]            bus_wdata;
    logic [7:0]            bus_rdata;
    logic                  bus_ack;
    logic                  bus_err;

    modport slave (
        input  read_line_req, read_req, write_through_req, pa, wt_data,
        input  bus_rdata, bus_ack, bus_err,
        output line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error,
        output bus_req, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output read_line_req, read_req, write_through_req, pa, wt_data,
        output bus_rdata, bus_ack, bus_err,
        input  line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error,
        input  bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/l1_biu_line_fetch.sv
// L1-I bus interface unit: turns line-fill / single read / write-through requests into
// byte beats on the 8-bit req/ack bus, with per-beat timeout and registered strobes.
module l1_biu_line_fetch #(
    parameter int ADDR_WIDTH = 24,
    parameter int LINE_SIZE  = 256,
    parameter int LINE_WID   = $clog2(LINE_SIZE),
    parameter int TIMEOUT    = 255
) (
    input logic               clk,
    input logic               rst,
    l1_biu_line_fetch_if.slave ifc
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_SREAD  = 3'd2;
    localparam logic [2:0] S_SWRITE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]            r_state;
    logic [TMR_W-1:0]      r_timer;
    logic [LINE_WID-1:0]   r_beat_cnt;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [7:0]            r_bus_wdata;
    logic [7:0]            r_line_data;
    logic [LINE_WID-1:0]   r_addr_count;
    logic                  r_line_write;
    logic                  r_refill;
    logic                  r_trans_rdy;
    logic                  r_bus_error;

    logic w_timeout;
    logic w_fail;
    logic w_last;

    // The timer's last legal value is the TIMEOUT-th cycle of a beat; err beats ack.
    assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_fail    = ifc.bus_err | w_timeout;
    assign w_last    = (r_beat_cnt == LINE_WID'(LINE_SIZE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_beat_cnt   <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_line_data  <= '0;
            r_addr_count <= '0;
            r_line_write <= 1'b0;
            r_refill     <= 1'b0;
            r_trans_rdy  <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_line_write <= 1'b0;
            r_refill     <= 1'b0;
            r_trans_rdy  <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (ifc.read_line_req) begin
                        r_state    <= S_FILL;
                        r_bus_req  <= 1'b1;
                        r_bus_we   <= 1'b0;
                        r_bus_addr <= {ifc.pa[ADDR_WIDTH-1:LINE_WID], LINE_WID'(0)};
                        r_beat_cnt <= '0;
                    end else if (ifc.read_req) begin
                        r_state    <= S_SREAD;
                        r_bus_req  <= 1'b1;
                        r_bus_we   <= 1'b0;
                        r_bus_addr <= ifc.pa;
                    end else if (ifc.write_through_req) begin
                        r_state     <= S_SWRITE;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b1;
                        r_bus_addr  <= ifc.pa;
                        r_bus_wdata <= ifc.wt_data;
                    end
                end
                S_FILL, S_SREAD, S_SWRITE: begin
                    if (w_fail) begin
                        r_state     <= S_ERR;
                        r_bus_req   <= 1'b0;
                        r_bus_we    <= 1'b0;
                        r_bus_error <= 1'b1;
                    end else if (ifc.bus_ack) begin
                        r_timer <= '0;
                        if (r_state != S_SWRITE) begin
                            r_line_data <= ifc.bus_rdata;
                        end
                        // Back-to-back fill beats keep bus_req high; the final ack completes.
                        if (r_state == S_FILL) begin
                            r_addr_count <= r_beat_cnt;
                            r_line_write <= 1'b1;
                            if (w_last) begin
                                r_state     <= S_DONE;
                                r_bus_req   <= 1'b0;
                                r_refill    <= 1'b1;
                                r_trans_rdy <= 1'b1;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + LINE_WID'(1);
                                r_bus_addr <= r_bus_addr + ADDR_WIDTH'(1);
                            end
                        end else begin
                            r_state     <= S_DONE;
                            r_bus_req   <= 1'b0;
                            r_bus_we    <= 1'b0;
                            r_trans_rdy <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                    r_bus_we  <= 1'b0;
                end
            endcase
        end
    end

    assign ifc.bus_req            = r_bus_req;
    assign ifc.bus_we             = r_bus_we;
    assign ifc.bus_addr           = r_bus_addr;
    assign ifc.bus_wdata          = r_bus_wdata;
    assign ifc.line_data          = r_line_data;
    assign ifc.addr_count         = r_addr_count;
    assign ifc.line_write         = r_line_write;
    assign ifc.cache_entry_refill = r_refill;
    assign ifc.trans_rdy          = r_trans_rdy;
    assign ifc.bus_error          = r_bus_error;
endmodule
